// File: rtl/lane_obstacle_engine_pkg.sv
// Shared game constants: lane encoding, obstacle geometry, screen limit and the
// lane-picking LFSR parameters used by the controller, renderer and obstacle engine.
package lane_obstacle_engine_pkg;

   localparam int          LANE_COUNT    = 3;
   localparam logic [1:0]  NO_LANE       = 2'd3;
   localparam logic [1:0]  LANE3_MAP     = 2'd1;
   localparam int          OBSTACLE_H    = 40;
   localparam int          SCREEN_HEIGHT = 480;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;

   typedef logic [1:0] lane_t;

   // Raw LFSR bits only give four codes; the spare code folds onto the middle lane.
   function automatic lane_t map_lane(input logic [1:0] raw);
      return (raw == NO_LANE) ? LANE3_MAP : raw;
   endfunction

endpackage

// File: rtl/lane_obstacle_engine_lfsr16.sv
// 16-bit Galois LFSR, free-running from reset; a non-zero seed keeps it off the all-zero lockup state.
module lfsr16
   import lane_obstacle_engine_pkg::*;
(
   input  logic        Clock,
   input  logic        Resetn,
   output logic [15:0] value
);

   always_ff @(posedge Clock) begin
      if (!Resetn)
         value <= LFSR_SEED;
      else
         value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
   end

endmodule

// File: rtl/lane_obstacle_engine.sv
// Falling-obstacle engine: timed spawn and movement of a fixed pool of slots,
// plus a registered player-overlap flag for the game controller.
module lane_obstacle_engine
   import lane_obstacle_engine_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int MOVE_DIV  = 500000,
   parameter int SPAWN_DIV = 50000000,
   parameter int STEP      = 4,
   parameter int SCREEN_H  = SCREEN_HEIGHT,
   parameter int PLAYER_Y  = 400,
   parameter int PLAYER_H  = 40
)
(
   input  logic                   Clock,
   input  logic                   Resetn,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [1:0]             player_lane,
   output logic                   collision,
   output logic [NUM_SLOTS-1:0]   obj_active,
   output logic [2*NUM_SLOTS-1:0] obj_lane,
   output logic [9*NUM_SLOTS-1:0] obj_y
);

   localparam int MW = (MOVE_DIV  > 1) ? $clog2(MOVE_DIV)  : 1;
   localparam int SW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

   logic [MW-1:0]        move_cnt;
   logic [SW-1:0]        spawn_cnt;
   logic                 move_tick;
   logic                 spawn_tick;
   logic [15:0]          lfsr_value;
   logic                 unused_lfsr;
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic [NUM_SLOTS-1:0] hit;

   lfsr16 u_lfsr (
      .Clock  (Clock),
      .Resetn (Resetn),
      .value  (lfsr_value)
   );

   assign unused_lfsr = ^lfsr_value[15:2];

   assign move_tick  = enable && (move_cnt  == MW'(MOVE_DIV - 1));
   assign spawn_tick = enable && (spawn_cnt == SW'(SPAWN_DIV - 1));

   always_ff @(posedge Clock) begin
      if (!Resetn || clear) begin
         move_cnt  <= '0;
         spawn_cnt <= '0;
      end else if (enable) begin
         move_cnt  <= move_tick  ? '0 : move_cnt  + 1'b1;
         spawn_cnt <= spawn_tick ? '0 : spawn_cnt + 1'b1;
      end
   end

   // Picks from the pre-edge active flags, so a slot retiring this cycle is not refilled until the next spawn.
   always_comb begin
      spawn_sel = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!obj_active[i]) begin
            spawn_sel    = '0;
            spawn_sel[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      logic       act;
      lane_t      lane;
      logic [8:0] y;
      logic [9:0] next_y;

      assign next_y = {1'b0, y} + 10'(STEP);
      assign hit[g] = act && (player_lane != NO_LANE) && (lane == player_lane)
                      && (({1'b0, y} + 10'(OBSTACLE_H)) > 10'(PLAYER_Y))
                      && ({1'b0, y} < 10'(PLAYER_Y + PLAYER_H));

      // On retirement y keeps its last on-screen value; only the active flag drops.
      always_ff @(posedge Clock) begin
         if (!Resetn) begin
            act  <= 1'b0;
            lane <= '0;
            y    <= '0;
         end else if (clear) begin
            act <= 1'b0;
         end else if (spawn_tick && spawn_sel[g]) begin
            act  <= 1'b1;
            lane <= map_lane(lfsr_value[1:0]);
            y    <= '0;
         end else if (move_tick && act) begin
            if (next_y >= 10'(SCREEN_H))
               act <= 1'b0;
            else
               y <= next_y[8:0];
         end
      end

      assign obj_active[g]      = act;
      assign obj_lane[2*g +: 2] = lane;
      assign obj_y[9*g +: 9]    = y;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn || clear)
         collision <= 1'b0;
      else
         collision <= |hit;
   end

endmodule
